// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_M,
        ST_LOAD_Q,
        ST_ADDSUB,
        ST_SHIFT,
        ST_OUT_A,
        ST_OUT_Q
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic booth_op_t booth_op(input logic q0, input logic qm1);
        booth_op_t op;
        unique case ({q0, qm1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit adder/subtractor for the Booth accumulator.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    input  logic         sub,
    output logic [W-1:0] sum
);

    always_comb begin
        sum = sub ? (a - m) : (a + m);
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, product returned as hi/lo beats.
// Optional overflow flag on the last beat when BOOTH_MUL_OVF_EN is defined.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             out_hi,
    output logic             busy,
    output logic             done
`ifdef BOOTH_MUL_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   a_reg;
    logic             qm1;
    logic [CNT_W-1:0] cnt;

    booth_op_t      op;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] a_sum;
    logic           last_iter;

    assign op        = booth_op(q_reg[0], qm1);
    assign m_ext     = {m_reg[WIDTH-1], m_reg};
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    booth_addsub #(
        .W(WIDTH + 1)
    ) u_addsub (
        .a  (a_reg),
        .m  (m_ext),
        .sub(op == OP_SUB),
        .sum(a_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (start) state_nx = ST_LOAD_M;
            ST_LOAD_M: state_nx = ST_LOAD_Q;
            ST_LOAD_Q: state_nx = inbus[0] ? ST_ADDSUB : ST_SHIFT;
            ST_ADDSUB: state_nx = ST_SHIFT;
            ST_SHIFT: begin
                // The pair after this shift is {Q[1],Q[0]} of the current Q
                if (last_iter) begin
                    state_nx = ST_OUT_A;
                end else if (q_reg[1] != q_reg[0]) begin
                    state_nx = ST_ADDSUB;
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_OUT_A:  state_nx = ST_OUT_Q;
            ST_OUT_Q:  state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg <= '0;
            q_reg <= '0;
            a_reg <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_LOAD_M: m_reg <= inbus;
                ST_LOAD_Q: begin
                    q_reg <= inbus;
                    a_reg <= '0;
                    qm1   <= 1'b0;
                    cnt   <= '0;
                end
                ST_ADDSUB: a_reg <= a_sum;
                ST_SHIFT: begin
                    {a_reg, q_reg, qm1} <= {a_reg[WIDTH], a_reg, q_reg};
                    cnt                 <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        outbus    = '0;
        out_valid = 1'b0;
        out_hi    = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        unique case (1'b1)
            (state == ST_OUT_A): begin
                outbus    = a_reg[WIDTH-1:0];
                out_valid = 1'b1;
                out_hi    = 1'b1;
            end
            (state == ST_OUT_Q): begin
                outbus    = q_reg;
                out_valid = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef BOOTH_MUL_OVF_EN
    // Product fits in WIDTH signed bits only if the high half is all sign bits
    always_comb begin
        ovf = (state == ST_OUT_Q) &&
              (a_reg[WIDTH-1:0] != {WIDTH{q_reg[WIDTH-1]}});
    end
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH=8.
// Reference: plain signed multiply and Booth-pair count for latency.
module tb_booth_mul_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] inbus;
    logic [7:0] outbus;
    logic       out_valid;
    logic       out_hi;
    logic       busy;
    logic       done;
`ifdef BOOTH_MUL_OVF_EN
    logic       ovf;
`endif

    int vectors = 0;
    int errors  = 0;

    booth_mul_seq #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inbus    (inbus),
        .outbus   (outbus),
        .out_valid(out_valid),
        .out_hi   (out_hi),
        .busy     (busy),
        .done     (done)
`ifdef BOOTH_MUL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] mv, input logic [7:0] qv,
                         input bit spam);
        int         exp_p;
        logic [15:0] exp_b;
        logic [7:0] pairs;
        int         k;
        int         cyc;
        exp_p = $signed(mv) * $signed(qv);
        exp_b = exp_p[15:0];
        pairs = qv ^ {qv[6:0], 1'b0};
        k     = $countones(pairs);
        chk("idle_before", busy, 0);
        start = 1'b1;
        inbus = 8'($urandom);
        tick();
        cyc = 1;
        chk("busy_lm", busy, 1);
        start = spam ? 1'($urandom) : 1'b0;
        inbus = mv;
        tick();
        cyc++;
        inbus = qv;
        tick();
        cyc++;
        while (!out_valid && cyc < 40) begin
            if (spam) start = 1'($urandom);
            inbus = 8'($urandom);
            tick();
            cyc++;
        end
        if (!out_valid) begin
            chk("timeout", 0, 1);
            start = 1'b0;
            return;
        end
        chk("hi_flag", out_hi, 1);
        chk("hi_beat", outbus, exp_b[15:8]);
        chk("hi_done", done, 0);
        tick();
        cyc++;
        start = 1'b0;
        chk("lo_valid", out_valid, 1);
        chk("lo_flag", out_hi, 0);
        chk("lo_beat", outbus, exp_b[7:0]);
        chk("lo_done", done, 1);
        chk("latency", cyc, 12 + k);
`ifdef BOOTH_MUL_OVF_EN
        chk("ovf", ovf, (exp_p > 127 || exp_p < -128) ? 1 : 0);
`endif
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_bus", outbus, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        inbus = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bus", outbus, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_done", done, 0);
`ifdef BOOTH_MUL_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        tick();

        // Abort an op in its first ADDSUB cycle, start held high too
        start = 1'b1;
        tick();
        start = 1'b0;
        inbus = 8'h03;
        tick();
        inbus = 8'h05;
        tick();
        chk("mid_busy", busy, 1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_bus", outbus, 0);
        chk("abort_done", done, 0);

        do_op(8'h03, 8'h05, 1'b0);
        do_op(8'hFD, 8'h07, 1'b0);
        do_op(8'h80, 8'h80, 1'b0);
        do_op(8'($urandom), 8'h00, 1'b0);
        do_op(8'($urandom), 8'h55, 1'b0);
        do_op(8'h7F, 8'h80, 1'b1);
        do_op(8'h80, 8'h7F, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h00, 8'hAA, 1'b1);

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
